// File: rtl/gaussian_blurrer_1d_pkg.sv
// +----------------------------------------------------------------------+
// | blur_pkg : shared constants, state encoding and position clamping    |
// | for gaussian_blurrer_1d.                                             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package blur_pkg;

    localparam int LUMA_HI = 29;
    localparam int LUMA_LO = 20;
    localparam int CR_HI   = 19;
    localparam int CR_LO   = 10;
    localparam int CB_HI   = 9;
    localparam int CB_LO   = 0;

    localparam logic [9:0] NEUTRAL_CHROMA = 10'd512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_MAC   = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Replicates border pixels by pinning out-of-line positions to the edges.
    function automatic int clamp_pos(input int pos, input int len);
        if (pos < 0) begin
            return 0;
        end
        if (pos > len - 1) begin
            return len - 1;
        end
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gaussian_blurrer_1d_mac.sv
// +----------------------------------------------------------------------+
// | blur_mac : TAPS-cycle multiply-accumulate with round, shift and      |
// | saturation; result reflects the accumulation including this cycle.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module blur_mac #(
    parameter int                DATA_W     = 10,
    parameter int                TAPS       = 5,
    parameter logic [TAPS*8-1:0] COEFS      = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16},
    parameter int                NORM_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [$clog2(TAPS)-1:0]  k,
    input  logic [DATA_W-1:0]        sample,
    output logic [DATA_W-1:0]        result
);

    localparam int               c_acc_w = DATA_W + 8 + $clog2(TAPS);
    localparam logic [c_acc_w:0] c_half  = (c_acc_w + 1)'(1) << (NORM_SHIFT - 1);
    localparam logic [c_acc_w:0] c_max   = (c_acc_w + 1)'((1 << DATA_W) - 1);

    logic [7:0]         w_coef_tab [TAPS];
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_prod;
    logic [c_acc_w-1:0] w_acc_next;
    logic [c_acc_w:0]   w_rnd;
    logic [c_acc_w:0]   w_shr;

    genvar g;
    for (g = 0; g < TAPS; g++) begin : g_coef
        assign w_coef_tab[g] = COEFS[(TAPS-1-g)*8 +: 8];
    end

    always_comb begin
        w_prod     = c_acc_w'(w_coef_tab[k]) * c_acc_w'(sample);
        w_acc_next = en ? (r_acc + w_prod) : r_acc;
        w_rnd      = {1'b0, w_acc_next} + c_half;
        w_shr      = w_rnd >> NORM_SHIFT;
        result     = (w_shr > c_max) ? '1 : w_shr[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gaussian_blurrer_1d.sv
// +----------------------------------------------------------------------+
// | gaussian_blurrer_1d : border-clamped 1-D Gaussian pass (X or Y) from |
// | a YCrCb frame memory. GAUSS_PASS_CHROMA_EN forwards centre Cr/Cb.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module gaussian_blurrer_1d
    import blur_pkg::*;
#(
    parameter int                WIDTH        = 640,
    parameter int                HEIGHT       = 480,
    parameter int                X_BITS       = 10,
    parameter int                Y_BITS       = 9,
    parameter int                DATA_W       = 10,
    parameter int                TAPS         = 5,
    parameter logic [TAPS*8-1:0] COEFS        = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16},
    parameter int                NORM_SHIFT   = 8,
    parameter int                READ_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       dir,
    output logic                       busy,
    output logic                       done,
    output logic [X_BITS+Y_BITS-1:0]   read_addr,
    input  logic [35:0]                read_data,
    output logic                       write_en,
    output logic [X_BITS+Y_BITS-1:0]   write_addr,
    output logic [35:0]                write_data
);

    localparam int                  c_aw     = X_BITS + Y_BITS;
    localparam int                  c_r      = (TAPS - 1) / 2;
    localparam int                  c_kw     = $clog2(TAPS);
    localparam logic [c_kw-1:0]     c_k_last = c_kw'(TAPS - 1);

    state_t            r_state;
    logic              r_dir;
    logic              r_priming;
    int                r_pos;
    int                r_line;
    int                r_wait;
    logic [c_kw-1:0]   r_k;
    logic [DATA_W-1:0] r_win_y [TAPS];
    int                w_len;
    int                w_nlines;
    logic              w_shift;
    logic              w_mac_clr;
    logic              w_mac_en;
    logic [DATA_W-1:0] w_result;
    logic [9:0]        w_cr;
    logic [9:0]        w_cb;
    logic              w_unused_rd;

    function automatic logic [c_aw-1:0] pix_addr(input logic d, input int pos, input int line);
        int c;
        c = clamp_pos(pos, d ? HEIGHT : WIDTH);
        if (d) begin
            return {Y_BITS'(c), X_BITS'(line)};
        end
        return {Y_BITS'(line), X_BITS'(c)};
    endfunction

    always_comb begin
        w_len     = r_dir ? HEIGHT : WIDTH;
        w_nlines  = r_dir ? WIDTH : HEIGHT;
        w_shift   = (r_state == ST_WAIT) && (r_wait == READ_LATENCY - 1);
        w_mac_clr = w_shift && !r_priming;
        w_mac_en  = (r_state == ST_MAC);
    end

    // Window: oldest sample at tap 0, newest enters tap TAPS-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_win_y[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                r_win_y[i] <= r_win_y[i+1];
            end
            r_win_y[TAPS-1] <= DATA_W'(read_data[LUMA_HI:LUMA_LO]);
        end
    end

`ifdef GAUSS_PASS_CHROMA_EN
    logic [9:0] r_win_cr [TAPS];
    logic [9:0] r_win_cb [TAPS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_win_cr[i] <= '0;
                r_win_cb[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                r_win_cr[i] <= r_win_cr[i+1];
                r_win_cb[i] <= r_win_cb[i+1];
            end
            r_win_cr[TAPS-1] <= read_data[CR_HI:CR_LO];
            r_win_cb[TAPS-1] <= read_data[CB_HI:CB_LO];
        end
    end

    assign w_cr        = r_win_cr[c_r];
    assign w_cb        = r_win_cb[c_r];
    assign w_unused_rd = &{1'b0, read_data[35:30]};
`else
    assign w_cr        = NEUTRAL_CHROMA;
    assign w_cb        = NEUTRAL_CHROMA;
    assign w_unused_rd = &{1'b0, read_data[35:30], read_data[CR_HI:CB_LO]};
`endif

    blur_mac #(
        .DATA_W     (DATA_W),
        .TAPS       (TAPS),
        .COEFS      (COEFS),
        .NORM_SHIFT (NORM_SHIFT)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_mac_clr),
        .en     (w_mac_en),
        .k      (r_k),
        .sample (r_win_y[r_k]),
        .result (w_result)
    );

    // read_addr is loaded on the edge entering PRIME/FETCH so it is valid in that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_dir      <= 1'b0;
            r_priming  <= 1'b0;
            r_pos      <= 0;
            r_line     <= 0;
            r_wait     <= 0;
            r_k        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            write_en   <= 1'b0;
            read_addr  <= '0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            done     <= 1'b0;
            write_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dir     <= dir;
                        r_line    <= 0;
                        r_pos     <= -c_r;
                        r_priming <= 1'b1;
                        read_addr <= pix_addr(dir, -c_r, 0);
                        busy      <= 1'b1;
                        r_state   <= ST_PRIME;
                    end
                end
                ST_PRIME, ST_FETCH: begin
                    r_wait  <= 0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == READ_LATENCY - 1) begin
                        if (!r_priming) begin
                            r_k     <= '0;
                            r_state <= ST_MAC;
                        end else if (r_pos == c_r - 1) begin
                            r_priming <= 1'b0;
                            r_pos     <= 0;
                            read_addr <= pix_addr(r_dir, c_r, r_line);
                            r_state   <= ST_FETCH;
                        end else begin
                            r_pos     <= r_pos + 1;
                            read_addr <= pix_addr(r_dir, r_pos + 1, r_line);
                            r_state   <= ST_PRIME;
                        end
                    end else begin
                        r_wait <= r_wait + 1;
                    end
                end
                ST_MAC: begin
                    if (r_k == c_k_last) begin
                        write_en   <= 1'b1;
                        write_addr <= pix_addr(r_dir, r_pos, r_line);
                        write_data <= {6'b0, 10'(w_result), w_cr, w_cb};
                        r_state    <= ST_WRITE;
                    end else begin
                        r_k <= r_k + c_kw'(1);
                    end
                end
                ST_WRITE: begin
                    if (r_pos < w_len - 1) begin
                        r_pos     <= r_pos + 1;
                        read_addr <= pix_addr(r_dir, r_pos + 1 + c_r, r_line);
                        r_state   <= ST_FETCH;
                    end else if (r_line < w_nlines - 1) begin
                        r_line    <= r_line + 1;
                        r_pos     <= -c_r;
                        r_priming <= 1'b1;
                        read_addr <= pix_addr(r_dir, -c_r, r_line + 1);
                        r_state   <= ST_PRIME;
                    end else begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gaussian_blurrer_1d.sv
// +----------------------------------------------------------------------+
// | tb_gaussian_blurrer_1d : scoreboard bench for gaussian_blurrer_1d on |
// | an 8x4 image with a 2-cycle read-latency memory model.               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gaussian_blurrer_1d;

    localparam int c_w     = 8;
    localparam int c_h     = 4;
    localparam int c_limit = 2000;

    typedef struct packed {
        logic [4:0]  a;
        logic [35:0] d;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        dir;
    logic        busy;
    logic        done;
    logic [4:0]  read_addr;
    logic [35:0] read_data;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [35:0] write_data;

    logic [35:0] mem    [32];
    logic [35:0] pipe0;
    logic [35:0] pipe1;
    logic [35:0] cap_d  [32];
    exp_t        exp_q  [$];
    exp_t        mon_e;
    int          coef   [5] = '{16, 64, 96, 64, 16};
    int          checks = 0;
    int          errors = 0;
    int          n_writes;

    gaussian_blurrer_1d #(
        .WIDTH        (c_w),
        .HEIGHT       (c_h),
        .X_BITS       (3),
        .Y_BITS       (2),
        .DATA_W       (10),
        .TAPS         (5),
        .COEFS        ({8'd16, 8'd64, 8'd96, 8'd64, 8'd16}),
        .NORM_SHIFT   (8),
        .READ_LATENCY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe1 <= pipe0;
        pipe0 <= mem[read_addr];
    end
    assign read_data = pipe1;

    always @(negedge clk) begin
        if (reset && write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%h", write_addr, write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({write_addr, write_data} !== {mon_e.a, mon_e.d}) begin
                    errors++;
                    $display("FAIL write_data got addr=%0d Y=%0d Cr=%0d Cb=%0d want addr=%0d Y=%0d Cr=%0d Cb=%0d",
                             write_addr, write_data[29:20], write_data[19:10], write_data[9:0],
                             mon_e.a, mon_e.d[29:20], mon_e.d[19:10], mon_e.d[9:0]);
                end
            end
            cap_d[write_addr] = write_data;
            n_writes++;
        end
    end

    function automatic int lum(input int x, input int y);
        return int'(mem[y*c_w + x][29:20]);
    endfunction

    function automatic int clampi(input int v, input int len);
        if (v < 0) return 0;
        if (v > len - 1) return len - 1;
        return v;
    endfunction

    task automatic build_expected(input logic d);
        int   len, nl, acc, pos, x, y, yv;
        exp_t e;
        len = d ? c_h : c_w;
        nl  = d ? c_w : c_h;
        for (int line = 0; line < nl; line++) begin
            for (int p = 0; p < len; p++) begin
                acc = 0;
                for (int k = 0; k < 5; k++) begin
                    pos = clampi(p - 2 + k, len);
                    x   = d ? line : pos;
                    y   = d ? pos : line;
                    acc += coef[k] * lum(x, y);
                end
                yv = (acc + 128) >> 8;
                if (yv > 1023) yv = 1023;
                x = d ? line : p;
                y = d ? p : line;
                e.a = 5'(y*c_w + x);
`ifdef GAUSS_PASS_CHROMA_EN
                e.d = {6'b0, 10'(yv), mem[y*c_w + x][19:0]};
`else
                e.d = {6'b0, 10'(yv), 10'd512, 10'd512};
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_const(input int yv, input int cr, input int cb);
        for (int i = 0; i < 32; i++) mem[i] = {6'b0, 10'(yv), 10'(cr), 10'(cb)};
    endtask

    task automatic run_frame(input logic d, input int extra_start, output int cyc);
        for (int i = 0; i < 32; i++) cap_d[i] = 'x;
        n_writes = 0;
        build_expected(d);
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        @(negedge clk);
        start = 1'b0;
        dir   = ~d;
        cyc   = 1;
        checks++;
        if (busy !== 1'b1 || read_addr !== 5'd0) begin
            errors++;
            $display("FAIL first_cycle busy=%b read_addr=%0d want busy=1 read_addr=0", busy, read_addr);
        end
        while (!done && cyc < c_limit) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start);
        end
        start = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout cycles=%0d", cyc);
        end
    endtask

    task automatic check_frame_end(input int cyc, input int want_cyc);
        checks++;
        if (cyc !== want_cyc) begin
            errors++;
            $display("FAIL done_cycle got=%0d want=%0d", cyc, want_cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (n_writes !== 32 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL write_count got=%0d left=%0d want 32 0", n_writes, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, write_en} !== 3'b000 || read_addr !== 5'd0 ||
            write_addr !== 5'd0 || write_data !== 36'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b we=%b ra=%0d wa=%0d wd=%h want all 0",
                     busy, done, write_en, read_addr, write_addr, write_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_constant();
        int cyc;
        fill_const(300, 512, 512);
        run_frame(1'b0, 0, cyc);
        check_frame_end(cyc, 337);
        checks++;
        if (cap_d[13][29:20] !== 10'd300) begin
            errors++;
            $display("FAIL const_y got=%0d want=300", cap_d[13][29:20]);
        end
    endtask

    task automatic test_impulse_x();
        int cyc;
        int want [5] = '{16, 64, 96, 64, 16};
        fill_const(0, 512, 512);
        mem[2*c_w + 4] = {6'b0, 10'd256, 10'd512, 10'd512};
        run_frame(1'b0, 0, cyc);
        check_frame_end(cyc, 337);
        for (int x = 2; x <= 6; x++) begin
            checks++;
            if (cap_d[2*c_w + x][29:20] !== 10'(want[x-2])) begin
                errors++;
                $display("FAIL impulse_x x=%0d got=%0d want=%0d", x, cap_d[2*c_w + x][29:20], want[x-2]);
            end
        end
        checks++;
        if (cap_d[2*c_w + 0][29:20] !== 10'd0 || cap_d[1*c_w + 4][29:20] !== 10'd0) begin
            errors++;
            $display("FAIL impulse_x_zero got=%0d,%0d want=0,0", cap_d[2*c_w][29:20], cap_d[c_w + 4][29:20]);
        end
    endtask

    task automatic test_ramp();
        int cyc;
        fill_const(0, 512, 512);
        for (int x = 0; x < c_w; x++) mem[x] = {6'b0, 10'(x*100), 10'd512, 10'd512};
        run_frame(1'b0, 0, cyc);
        check_frame_end(cyc, 337);
        checks++;
        if (cap_d[0][29:20] !== 10'd38 || cap_d[7][29:20] !== 10'd663) begin
            errors++;
            $display("FAIL ramp_edges got=%0d,%0d want=38,663", cap_d[0][29:20], cap_d[7][29:20]);
        end
    endtask

    task automatic test_impulse_y();
        int cyc;
        int want [4] = '{64, 96, 64, 16};
        fill_const(0, 512, 512);
        mem[1*c_w + 1] = {6'b0, 10'd256, 10'd512, 10'd512};
        run_frame(1'b1, 0, cyc);
        check_frame_end(cyc, 8*(12 + 4*9) + 1);
        for (int y = 0; y < 4; y++) begin
            checks++;
            if (cap_d[y*c_w + 1][29:20] !== 10'(want[y])) begin
                errors++;
                $display("FAIL impulse_y y=%0d got=%0d want=%0d", y, cap_d[y*c_w + 1][29:20], want[y]);
            end
        end
    endtask

    task automatic test_saturation();
        int         cyc;
        logic [19:0] want_c;
`ifdef GAUSS_PASS_CHROMA_EN
        want_c = {10'd100, 10'd900};
`else
        want_c = {10'd512, 10'd512};
`endif
        fill_const(1023, 100, 900);
        run_frame(1'b0, 0, cyc);
        check_frame_end(cyc, 337);
        checks++;
        if (cap_d[5][29:20] !== 10'd1023 || cap_d[5][19:0] !== want_c) begin
            errors++;
            $display("FAIL saturation got Y=%0d C=%h want Y=1023 C=%h", cap_d[5][29:20], cap_d[5][19:0], want_c);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        fill_const(0, 512, 512);
        mem[2*c_w + 4] = {6'b0, 10'd256, 10'd512, 10'd512};
        build_expected(1'b0);
        @(negedge clk);
        start = 1'b1;
        dir   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!write_en && cyc < c_limit) begin
            @(negedge clk);
            cyc++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, write_en, done} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_reset busy=%b we=%b done=%b want 0 0 0", busy, write_en, done);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_frame(1'b0, 0, cyc);
        check_frame_end(cyc, 337);
    endtask

    task automatic test_back_to_back();
        int cyc;
        fill_const(0, 512, 512);
        for (int i = 0; i < 32; i++) mem[i] = {6'b0, 10'((i*37) % 1024), 10'(i*3), 10'(1000 - i)};
        run_frame(1'b0, 50, cyc);
        check_frame_end(cyc, 337);
        run_frame(1'b1, 200, cyc);
        check_frame_end(cyc, 385);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        pipe0 = '0;
        pipe1 = '0;
        test_reset();
        test_constant();
        test_impulse_x();
        test_ramp();
        test_impulse_y();
        test_saturation();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
